// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg: shared ALU operation codes, execute FSM state encodings,
// misalignment trap cause codes and opcode classification helpers.
package exec_ctrl_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // ALU operation codes (6-bit alucode from the decoder)
    localparam logic [5:0] ALU_LUI  = 6'd0;
    localparam logic [5:0] ALU_JAL  = 6'd1;
    localparam logic [5:0] ALU_JALR = 6'd2;
    localparam logic [5:0] ALU_BEQ  = 6'd3;
    localparam logic [5:0] ALU_BNE  = 6'd4;
    localparam logic [5:0] ALU_BLT  = 6'd5;
    localparam logic [5:0] ALU_BGE  = 6'd6;
    localparam logic [5:0] ALU_BLTU = 6'd7;
    localparam logic [5:0] ALU_BGEU = 6'd8;
    localparam logic [5:0] ALU_LB   = 6'd9;
    localparam logic [5:0] ALU_LH   = 6'd10;
    localparam logic [5:0] ALU_LW   = 6'd11;
    localparam logic [5:0] ALU_LBU  = 6'd12;
    localparam logic [5:0] ALU_LHU  = 6'd13;
    localparam logic [5:0] ALU_SB   = 6'd14;
    localparam logic [5:0] ALU_SH   = 6'd15;
    localparam logic [5:0] ALU_SW   = 6'd16;
    localparam logic [5:0] ALU_ADD  = 6'd17;
    localparam logic [5:0] ALU_SUB  = 6'd18;
    localparam logic [5:0] ALU_XOR  = 6'd19;
    localparam logic [5:0] ALU_OR   = 6'd20;
    localparam logic [5:0] ALU_AND  = 6'd21;
    localparam logic [5:0] ALU_SLL  = 6'd22;
    localparam logic [5:0] ALU_SRL  = 6'd23;
    localparam logic [5:0] ALU_SRA  = 6'd24;
    localparam logic [5:0] ALU_SLT  = 6'd25;
    localparam logic [5:0] ALU_SLTU = 6'd26;

    // Execute FSM state encodings
    typedef enum logic [1:0] {
        EXEC_ST_IDLE = 2'd0,
        EXEC_ST_EXEC = 2'd1,
        EXEC_ST_MEM  = 2'd2,
        EXEC_ST_WB   = 2'd3
    } exec_state_t;

    // Misalignment trap causes
    localparam logic [1:0] TRAP_NONE   = 2'd0;
    localparam logic [1:0] TRAP_HALF   = 2'd1;
    localparam logic [1:0] TRAP_WORD   = 2'd2;
    localparam logic [1:0] TRAP_TARGET = 2'd3;

    function automatic logic is_load(input logic [5:0] code);
        return (code == ALU_LB) || (code == ALU_LH) || (code == ALU_LW) ||
               (code == ALU_LBU) || (code == ALU_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] code);
        return (code == ALU_SB) || (code == ALU_SH) || (code == ALU_SW);
    endfunction

    function automatic logic is_branch(input logic [5:0] code);
        return (code == ALU_BEQ) || (code == ALU_BNE) || (code == ALU_BLT) ||
               (code == ALU_BGE) || (code == ALU_BLTU) || (code == ALU_BGEU);
    endfunction

    function automatic logic is_jump(input logic [5:0] code);
        return (code == ALU_JAL) || (code == ALU_JALR);
    endfunction

endpackage

// File: rtl/exec_ctrl_mem_align.sv
// exec_ctrl_mem_align: combinational data-memory lane alignment (mem_align).
// Produces store strobes and replicated store data, extends load data from
// the addressed lane, and flags halfword/word accesses that are misaligned.
module exec_ctrl_mem_align
    import exec_ctrl_pkg::*;
(
    input  logic [5:0]  i_alucode,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and halfword lanes of the read word
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Per-opcode strobes, lane replication, load extension and alignment check
    always_comb begin
        o_wstrb     = 4'b0000;
        o_wdata     = 32'd0;
        o_load_data = 32'd0;
        o_misalign  = 1'b0;
        case (i_alucode)
            ALU_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
            ALU_LBU: o_load_data = {24'd0, w_byte};
            ALU_LH: begin
                o_load_data = {{16{w_half[15]}}, w_half};
                o_misalign  = i_addr_lo[0];
            end
            ALU_LHU: begin
                o_load_data = {16'd0, w_half};
                o_misalign  = i_addr_lo[0];
            end
            ALU_LW: begin
                o_load_data = i_rdata;
                o_misalign  = |i_addr_lo;
            end
            ALU_SB: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_store_data[7:0]}};
            end
            ALU_SH: begin
                o_wstrb    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata    = {2{i_store_data[15:0]}};
                o_misalign = i_addr_lo[0];
            end
            ALU_SW: begin
                o_wstrb    = 4'b1111;
                o_wdata    = i_store_data;
                o_misalign = |i_addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: multi-cycle execute-stage controller for one RV32I instruction
// at a time. Latches decoded operands, drives the external ALU for one cycle,
// issues a data-memory transaction for loads/stores, then pulses writeback
// and/or fetch redirect.
// Optional feature macro: EXEC_MISALIGN_TRAP_EN (misalignment trap checks).
//
// state | meaning
// IDLE  | dec_ready high, waiting for a decoded instruction
// EXEC  | ALU driven from latched fields, result/branch outcome captured
// MEM   | memory request held until mem_ack, load data captured
// WB    | one-cycle writeback / redirect / trap pulses
module exec_ctrl
    import exec_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [5:0]  dec_alucode,
    input  logic [31:0] dec_op1,
    input  logic [31:0] dec_op2,
    input  logic [31:0] dec_store_data,
    input  logic [31:0] dec_pc,
    input  logic [31:0] dec_imm,
    input  logic [4:0]  dec_rd,
    output logic [5:0]  alu_code,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    input  logic [31:0] alu_result,
    input  logic        alu_br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        redir_valid,
    output logic [31:0] redir_target,
    output logic        trap_valid,
    output logic [1:0]  trap_cause
);

    exec_state_t r_state;
    exec_state_t w_state_nxt;

    logic        r_rst_done;
    logic [5:0]  r_code;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [31:0] r_sdata;
    logic [31:0] r_pc;
    logic [31:0] r_imm;
    logic [4:0]  r_rd;
    logic [31:0] r_addr;
    logic [31:0] r_wb_data;
    logic [31:0] r_target;
    logic        r_wb_en;
    logic        r_redir_en;

    logic        w_idle;
    logic        w_exec;
    logic        w_mem;
    logic        w_wb;
    logic        w_accept;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_is_branch;
    logic        w_writes_rd;
    logic        w_redir_take;
    logic [31:0] w_target;
    logic [1:0]  w_addr_lo;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic        w_misalign;
    logic        w_trap_hit;

    assign w_idle = (r_state == EXEC_ST_IDLE);
    assign w_exec = (r_state == EXEC_ST_EXEC);
    assign w_mem  = (r_state == EXEC_ST_MEM);
    assign w_wb   = (r_state == EXEC_ST_WB);

    // dec_ready stays low until the first clock after reset release
    assign dec_ready = w_idle && r_rst_done;
    assign w_accept  = dec_valid && dec_ready;

    assign w_is_load    = is_load(r_code);
    assign w_is_store   = is_store(r_code);
    assign w_is_mem     = w_is_load || w_is_store;
    assign w_is_branch  = is_branch(r_code);
    assign w_writes_rd  = !w_is_branch && !w_is_store;
    assign w_redir_take = is_jump(r_code) || (w_is_branch && alu_br_taken);

    // Redirect adder: JALR uses rs1+imm with bit 0 cleared, others pc+imm
    always_comb begin
        w_target = r_pc + r_imm;
        if (r_code == ALU_JALR) begin
            w_target = (r_op1 + r_imm) & ~32'd1;
        end
    end

    // Lane select comes straight from the ALU during EXEC for the trap check,
    // and from the captured address while the request is outstanding
    assign w_addr_lo = w_exec ? alu_result[1:0] : r_addr[1:0];

    exec_ctrl_mem_align u_mem_align (
        .i_alucode    (r_code),
        .i_addr_lo    (w_addr_lo),
        .i_store_data (r_sdata),
        .i_rdata      (mem_rdata),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_misalign   (w_misalign)
    );

`ifdef EXEC_MISALIGN_TRAP_EN
    logic       r_trap;
    logic [1:0] r_trap_cause;
    logic [1:0] w_trap_cause;

    // Classify misaligned accesses and misaligned taken redirects in EXEC
    always_comb begin
        w_trap_hit   = 1'b0;
        w_trap_cause = TRAP_NONE;
        if (w_is_mem && w_misalign) begin
            w_trap_hit   = 1'b1;
            w_trap_cause = ((r_code == ALU_LW) || (r_code == ALU_SW)) ? TRAP_WORD : TRAP_HALF;
        end else if (w_redir_take && (w_target[1:0] != 2'b00)) begin
            w_trap_hit   = 1'b1;
            w_trap_cause = TRAP_TARGET;
        end
    end

    // Hold the trap outcome from EXEC until the WB pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap       <= DISABLE;
            r_trap_cause <= TRAP_NONE;
        end else if (w_exec) begin
            r_trap       <= w_trap_hit;
            r_trap_cause <= w_trap_cause;
        end
    end

    assign trap_valid = w_wb && r_trap;
    assign trap_cause = trap_valid ? r_trap_cause : TRAP_NONE;
`else
    logic w_unused_misalign;
    assign w_unused_misalign = w_misalign;
    assign w_trap_hit = 1'b0;
    assign trap_valid = 1'b0;
    assign trap_cause = TRAP_NONE;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EXEC_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EXEC_ST_IDLE: if (w_accept) w_state_nxt = EXEC_ST_EXEC;
            EXEC_ST_EXEC: begin
                if (w_trap_hit)    w_state_nxt = EXEC_ST_WB;
                else if (w_is_mem) w_state_nxt = EXEC_ST_MEM;
                else               w_state_nxt = EXEC_ST_WB;
            end
            EXEC_ST_MEM:  if (mem_ack) w_state_nxt = EXEC_ST_WB;
            EXEC_ST_WB:   w_state_nxt = EXEC_ST_IDLE;
            default:      w_state_nxt = EXEC_ST_IDLE;
        endcase
    end

    // Marks the first clock edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done <= DISABLE;
        end else begin
            r_rst_done <= ENABLE;
        end
    end

    // Operand latches and result capture across EXEC and MEM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code     <= 6'd0;
            r_op1      <= 32'd0;
            r_op2      <= 32'd0;
            r_sdata    <= 32'd0;
            r_pc       <= 32'd0;
            r_imm      <= 32'd0;
            r_rd       <= 5'd0;
            r_addr     <= 32'd0;
            r_wb_data  <= 32'd0;
            r_target   <= 32'd0;
            r_wb_en    <= DISABLE;
            r_redir_en <= DISABLE;
        end else begin
            if (w_accept) begin
                r_code  <= dec_alucode;
                r_op1   <= dec_op1;
                r_op2   <= dec_op2;
                r_sdata <= dec_store_data;
                r_pc    <= dec_pc;
                r_imm   <= dec_imm;
                r_rd    <= dec_rd;
            end
            if (w_exec) begin
                r_addr     <= alu_result;
                r_wb_data  <= alu_result;
                r_target   <= w_target;
                r_wb_en    <= w_writes_rd && (r_rd != 5'd0) && !w_trap_hit;
                r_redir_en <= w_redir_take && !w_trap_hit;
            end
            if (w_mem && mem_ack && w_is_load) begin
                r_wb_data <= w_load_data;
            end
        end
    end

    assign alu_code = w_exec ? r_code : 6'd0;
    assign alu_op1  = w_exec ? r_op1  : 32'd0;
    assign alu_op2  = w_exec ? r_op2  : 32'd0;

    // Memory outputs are pure functions of state so reset drops them at once
    assign mem_req   = w_mem;
    assign mem_we    = w_mem && w_is_store;
    assign mem_addr  = w_mem ? r_addr : 32'd0;
    assign mem_wdata = (w_mem && w_is_store) ? w_wdata : 32'd0;
    assign mem_wstrb = (w_mem && w_is_store) ? w_wstrb : 4'b0000;

    assign wb_valid     = w_wb && r_wb_en;
    assign wb_rd        = wb_valid ? r_rd : 5'd0;
    assign wb_data      = wb_valid ? r_wb_data : 32'd0;
    assign redir_valid  = w_wb && r_redir_en;
    assign redir_target = redir_valid ? r_target : 32'd0;

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: scoreboard bench for exec_ctrl. The bench plays the ALU and
// data memory; a reference model pushes expected events, a monitor pops them.
module tb_exec_ctrl;
    import exec_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    logic        dec_ready;
    logic [5:0]  dec_alucode;
    logic [31:0] dec_op1, dec_op2, dec_store_data, dec_pc, dec_imm;
    logic [4:0]  dec_rd;
    logic [5:0]  alu_code;
    logic [31:0] alu_op1, alu_op2, alu_result;
    logic        alu_br_taken;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        wb_valid, redir_valid, trap_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, redir_target;
    logic [1:0]  trap_cause;

    exec_ctrl dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_alucode(dec_alucode), .dec_op1(dec_op1), .dec_op2(dec_op2),
        .dec_store_data(dec_store_data), .dec_pc(dec_pc), .dec_imm(dec_imm),
        .dec_rd(dec_rd), .alu_code(alu_code), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .alu_br_taken(alu_br_taken), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .trap_valid(trap_valid), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural ALU: {br_taken, result}
    function automatic logic [32:0] alu_fn(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        t;
        r = 32'd0;
        t = 1'b0;
        case (c)
            ALU_SUB:  r = a - b;
            ALU_XOR:  r = a ^ b;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $signed(a) >>> b[4:0];
            ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_LUI:  r = b;
            ALU_JAL, ALU_JALR: r = b + 32'd4;
            ALU_BEQ:  t = (a == b);
            ALU_BNE:  t = (a != b);
            ALU_BLT:  t = ($signed(a) < $signed(b));
            ALU_BGE:  t = ($signed(a) >= $signed(b));
            ALU_BLTU: t = (a < b);
            ALU_BGEU: t = (a >= b);
            default:  r = a + b;
        endcase
        return {t, r};
    endfunction

    logic [32:0] alu_out;
    always_comb alu_out = alu_fn(alu_code, alu_op1, alu_op2);
    assign alu_result   = alu_out[31:0];
    assign alu_br_taken = alu_out[32];

    // kind: 0 memory request, 1 writeback, 2 redirect, 3 trap
    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  strb;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_mem;
    logic prev_req = 1'b0;

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got unexpected pulse expected none/other (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the expected event whenever the DUT presents one
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req) begin
                if (!prev_req) begin
                    if (exp_q.size() == 0 || exp_q[0].kind != 0) unexpected("mem_req");
                    else begin
                        mon_mem = exp_q.pop_front();
                        check("mem_req_cycle", 32'(cyc), 32'(mon_mem.cyc));
                    end
                end
                check("mem_addr", mem_addr, mon_mem.a);
                check("mem_we", {31'd0, mem_we}, {31'd0, mon_mem.we});
                if (mon_mem.we) begin
                    check("mem_wdata", mem_wdata, mon_mem.b);
                    check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, mon_mem.strb});
                end
            end
            prev_req = mem_req;
            if (wb_valid) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 1) unexpected("wb_valid");
                else begin
                    mon_e = exp_q.pop_front();
                    check("wb_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("wb_rd", {27'd0, wb_rd}, mon_e.a);
                    check("wb_data", wb_data, mon_e.b);
                end
            end
            if (redir_valid) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 2) unexpected("redir_valid");
                else begin
                    mon_e = exp_q.pop_front();
                    check("redir_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("redir_target", redir_target, mon_e.a);
                end
            end
            if (trap_valid) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 3) unexpected("trap_valid");
                else begin
                    mon_e = exp_q.pop_front();
                    check("trap_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("trap_cause", {30'd0, trap_cause}, mon_e.a);
                end
            end
        end else begin
            prev_req = 1'b0;
        end
    end

    task automatic push(input int kind, input int c, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] strb, input logic we);
        exp_t e;
        e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.strb = strb; e.we = we;
        exp_q.push_back(e);
    endtask

    task automatic garbage();
        dec_valid      = 1'($urandom % 2);
        dec_alucode    = 6'($urandom % 27);
        dec_op1        = $urandom;
        dec_op2        = $urandom;
        dec_store_data = $urandom;
        dec_pc         = $urandom;
        dec_imm        = $urandom;
        dec_rd         = 5'($urandom);
    endtask

    function automatic logic [31:0] all_out_or();
        return {31'd0, |{dec_ready, alu_code, alu_op1, alu_op2, mem_req, mem_we, mem_addr,
                         mem_wdata, mem_wstrb, wb_valid, wb_rd, wb_data, redir_valid,
                         redir_target, trap_valid, trap_cause}};
    endfunction

    // Issue one instruction at an IDLE negedge; reference model pushes expectations
    task automatic run_instr(input logic [5:0] code, input logic [31:0] op1, input logic [31:0] op2,
                             input logic [31:0] sdata, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [4:0] rd, input int waits, input logic [31:0] rdata);
        logic [32:0] ar;
        logic [31:0] addr, target, ld, lane, wd;
        logic [3:0]  strb;
        logic        ld_op, st_op, br_op, redir, trap;
        logic [1:0]  cause;
        int          hs, wbc;

        check("dec_ready_idle", {31'd0, dec_ready}, 32'd1);
        ar     = alu_fn(code, op1, op2);
        addr   = op1 + op2;
        ld_op  = code inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
        st_op  = code inside {ALU_SB, ALU_SH, ALU_SW};
        br_op  = code inside {ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
        redir  = (code == ALU_JAL) || (code == ALU_JALR) || (br_op && ar[32]);
        target = (code == ALU_JALR) ? ((op1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        trap   = 1'b0;
        cause  = 2'd0;
`ifdef EXEC_MISALIGN_TRAP_EN
        if ((code inside {ALU_LH, ALU_LHU, ALU_SH}) && addr[0]) begin trap = 1'b1; cause = 2'd1; end
        else if ((code inside {ALU_LW, ALU_SW}) && (addr[1:0] != 2'd0)) begin trap = 1'b1; cause = 2'd2; end
        else if (redir && (target[1:0] != 2'd0)) begin trap = 1'b1; cause = 2'd3; end
`endif
        lane = rdata >> (8 * int'(addr[1:0]));
        case (code)
            ALU_LB:  ld = 32'($signed(lane[7:0]));
            ALU_LBU: ld = {24'd0, lane[7:0]};
            ALU_LH:  ld = addr[1] ? 32'($signed(rdata[31:16])) : 32'($signed(rdata[15:0]));
            ALU_LHU: ld = addr[1] ? {16'd0, rdata[31:16]} : {16'd0, rdata[15:0]};
            default: ld = rdata;
        endcase
        case (code)
            ALU_SB:  begin strb = 4'b0001 << addr[1:0]; wd = {4{sdata[7:0]}}; end
            ALU_SH:  begin strb = addr[1] ? 4'b1100 : 4'b0011; wd = {2{sdata[15:0]}}; end
            default: begin strb = 4'b1111; wd = sdata; end
        endcase

        hs  = cyc;
        wbc = hs + 2 + (((ld_op || st_op) && !trap) ? waits + 1 : 0);
        if (trap) push(3, hs + 2, {30'd0, cause}, 0, 0, 0);
        else begin
            if (ld_op || st_op) push(0, hs + 2, addr, wd, strb, st_op);
            if (!br_op && !st_op && rd != 5'd0) push(1, wbc, {27'd0, rd}, ld_op ? ld : ar[31:0], 0, 0);
            if (redir) push(2, wbc, target, 0, 0, 0);
        end

        dec_valid = 1'b1; dec_alucode = code; dec_op1 = op1; dec_op2 = op2;
        dec_store_data = sdata; dec_pc = pc; dec_imm = imm; dec_rd = rd;
        @(negedge clk);
        check("alu_code_exec", {26'd0, alu_code}, {26'd0, code});
        check("alu_op1_exec", alu_op1, op1);
        check("alu_op2_exec", alu_op2, op2);
        garbage();
        mem_ack = 1'($urandom % 2);
        if ((ld_op || st_op) && !trap) begin
            for (int k = 0; k <= waits; k++) begin
                @(negedge clk);
                garbage();
                mem_ack   = (k == waits);
                mem_rdata = (k == waits) ? rdata : $urandom;
            end
        end
        @(negedge clk);
        garbage();
        mem_ack = 1'($urandom % 2);
        @(negedge clk);
        dec_valid = 1'b0;
        mem_ack   = 1'b0;
        check("alu_code_idle", {26'd0, alu_code}, 32'd0);
        check("alu_op1_idle", alu_op1, 32'd0);
    endtask

    task automatic reset_mid_mem();
        check("dec_ready_idle", {31'd0, dec_ready}, 32'd1);
        push(0, cyc + 2, 32'h0000_3000, 0, 0, 1'b0);
        dec_valid = 1'b1; dec_alucode = ALU_LW; dec_op1 = 32'h3000; dec_op2 = 32'd0;
        dec_store_data = 32'd0; dec_pc = 32'h80; dec_imm = 32'd0; dec_rd = 5'd7;
        @(negedge clk);
        dec_valid = 1'b0;
        mem_ack   = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_outputs", all_out_or(), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("dec_ready_after_rst", {31'd0, dec_ready}, 32'd1);
    endtask

    localparam logic [5:0] CODES [27] = '{ALU_LUI, ALU_JAL, ALU_JALR, ALU_BEQ, ALU_BNE, ALU_BLT,
        ALU_BGE, ALU_BLTU, ALU_BGEU, ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH,
        ALU_SW, ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU};

    initial begin
        logic [31:0] a, b;
        logic [5:0]  c;
        rst_n = 1'b0; dec_valid = 1'b0; dec_alucode = 6'd0; dec_op1 = 32'd0; dec_op2 = 32'd0;
        dec_store_data = 32'd0; dec_pc = 32'd0; dec_imm = 32'd0; dec_rd = 5'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        #3;
        check("reset_outputs", all_out_or(), 32'd0);
        repeat (2) @(negedge clk);
        check("reset_dec_ready", {31'd0, dec_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_instr(ALU_ADD, 32'd5, 32'd7, 32'd0, 32'h10, 32'd0, 5'd3, 0, 32'd0);
        run_instr(ALU_BEQ, 32'd9, 32'd9, 32'd0, 32'h100, 32'hFFFF_FFF8, 5'd0, 0, 32'd0);
        run_instr(ALU_BEQ, 32'd9, 32'd4, 32'd0, 32'h100, 32'hFFFF_FFF8, 5'd0, 0, 32'd0);
        run_instr(ALU_LB, 32'h1000, 32'd3, 32'd0, 32'h20, 32'd0, 5'd5, 3, 32'h80FF_0000);
        run_instr(ALU_SH, 32'h2000, 32'd2, 32'h1234_ABCD, 32'h24, 32'd0, 5'd9, 1, 32'd0);
        run_instr(ALU_JALR, 32'h203, 32'h40, 32'd0, 32'h40, 32'd0, 5'd1, 0, 32'd0);
        run_instr(ALU_JAL, 32'd0, 32'h200, 32'd0, 32'h200, 32'h0000_0010, 5'd0, 0, 32'd0);
        run_instr(ALU_LHU, 32'h400, 32'd2, 32'd0, 32'h28, 32'd0, 5'd31, 0, 32'hBEEF_1234);
        reset_mid_mem();

        for (int i = 0; i < 80; i++) begin
            c = CODES[$urandom % 27];
            a = $urandom;
            b = ($urandom % 2) ? a : $urandom;
            if (c inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW}) begin
                a = {$urandom % 32'h10000, 4'h0};
                b = $urandom % 8;
            end
            run_instr(c, a, b, $urandom, {$urandom % 32'h4000, 2'b00},
                      32'($signed(10'($urandom % 1024))) & 32'hFFFF_FFFE,
                      5'($urandom), int'($urandom % 4), $urandom);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Multi-cycle execute-stage controller that sequences the shared `alu` for one decoded RV32I instruction at a time. It registers decoded operands, drives the ALU, then issues a data-memory transaction for loads/stores. It produces a single-cycle writeback pulse and, for jumps and taken branches, a PC redirect pulse. It sits between the decoder and the register file/fetch unit and is the only driver of the ALU inputs.

## Interface
- No parameters; widths fixed at RV32 (32-bit data, 5-bit rd, 6-bit alucode from `define.vh`).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `dec_valid` in 1: decoded instruction available.
- `dec_ready` out 1: controller can accept; high only in IDLE.
- `dec_alucode` in 6: `ALU_*` code.
- `dec_op1`, `dec_op2` in 32: ALU operands, pre-selected by decoder. For JAL/JALR, op2 = pc; for JALR, op1 = rs1.
- `dec_store_data` in 32: rs2 value for stores.
- `dec_pc` in 32: instruction PC.
- `dec_imm` in 32: sign-extended branch/jump offset.
- `dec_rd` in 5: destination register.
- `alu_code` out 6, `alu_op1` out 32, `alu_op2` out 32: to ALU.
- `alu_result` in 32, `alu_br_taken` in 1: from ALU.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_wstrb` out 4: data-memory request.
- `mem_ack` in 1, `mem_rdata` in 32: data-memory response.
- `wb_valid` out 1, `wb_rd` out 5, `wb_data` out 32: register-file write.
- `redir_valid` out 1, `redir_target` out 32: fetch redirect.
- `trap_valid` out 1, `trap_cause` out 2: misalignment trap.

## Operation
- FSM states IDLE, EXEC, MEM, WB.
  - IDLE: `dec_ready`=1. On `dec_valid` the instruction and operands are latched and the FSM goes to EXEC.
  - EXEC: ALU is driven from the latched fields. `alu_result`/`alu_br_taken` are captured at the end of the cycle. Load/store goes to MEM; everything else goes to WB.
  - MEM: `mem_req`=1, with addr, we, wdata and wstrb held stable until the cycle `mem_ack`=1 is sampled. Then the FSM goes to WB, capturing `mem_rdata` for loads.
  - WB: one-cycle pulses, then IDLE.
- Writeback:
  - `wb_valid`=1 in WB only if the op writes rd (ALU ops, LUI, JAL/JALR, loads) and rd≠0.
  - Branches and stores never write back.
- Load extension by `addr[1:0]`: LB/LH sign-extend; LBU/LHU zero-extend; LW passes data through.
- Store strobes:
  - SB: `4'b0001<<addr[1:0]`, wdata = byte replicated ×4.
  - SH: `4'b0011<<{addr[1],1'b0}`, wdata = half replicated ×2.
  - SW: 4'b1111.
- Redirect targets:
  - JAL: pc+imm.
  - JALR: (op1+imm) & ~1.
  - BEQ..BGEU: pc+imm, only when the captured `br_taken`=1.
  - `redir_valid` pulses in WB.
- All sums are 32-bit modulo; wrap-around is ignored.
- `alu_*` outputs are 0 outside EXEC.

## Timing
- Every output resets to 0. State resets to IDLE.
- Non-memory op: accepted in cycle N; EXEC in N+1; `wb_valid`/`redir_valid` in N+2; `dec_ready` high again in N+3.
- Memory op: `mem_req` rises in N+2. An ack in the same cycle gives WB in N+3. Each wait cycle adds one.
- `mem_ack` outside MEM is ignored.
- `dec_valid` is ignored outside IDLE. The decoder must hold its fields only for the handshake cycle.
- Reset asserted mid-MEM drops `mem_req` immediately (async). The pending transaction is abandoned.

## Configuration
- `EXEC_MISALIGN_TRAP_EN` defined:
  - In EXEC, check LH/LHU/SH with addr[0]≠0 (cause 1), LW/SW with addr[1:0]≠0 (cause 2), and a taken redirect with target[1:0]≠0 (cause 3).
  - On a hit, skip MEM and suppress `wb_valid`/`redir_valid`.
  - `trap_valid`=1 with `trap_cause` in WB.
- Undefined:
  - `trap_valid`/`trap_cause` are tied 0.
  - Misaligned accesses are issued unchanged, with strobes per the shift rules above.
  - Redirect targets are passed unchanged.

## Structure
- `define.vh` (shared): existing `ALU_*` codes and `ENABLE`/`DISABLE`; add `EXEC_ST_*` state encodings and `TRAP_*` cause codes.
- One sub-module, `mem_align`, is combinational:
  - inputs: alucode, addr[1:0], store data, rdata;
  - outputs: wstrb, wdata, extended load data, misalign flag.
- `exec_ctrl` holds the FSM, operand latches and redirect adder.

## Test plan
- ADD with op1=5, op2=7, rd=3: `wb_valid` 2 cycles after handshake, `wb_data`=12; no redirect.
- BEQ with op1=op2=9, pc=0x100, imm=-8: `redir_valid` with target 0x0F8, no `wb_valid`. Repeat with op1≠op2: no pulses.
- LB at addr 0x1003, `mem_rdata`=0x80FF_0000, ack after 3 wait cycles: `mem_req` held for 4 cycles, `wb_data`=0xFFFF_FF80.
- SH at addr 0x2002, store data 0x1234_ABCD: `mem_wstrb`=4'b1100, `mem_wdata`=0xABCD_ABCD, `mem_we`=1, no writeback.
- JALR with op1=0x203, imm=0, op2=pc=0x40, rd=1: `wb_data`=0x44, target 0x202. With the macro defined, cause 3 and no redirect.
- `rst_n` pulsed low during MEM wait: all outputs 0 immediately; `dec_ready`=1 on the first edge after release.
